alu_seq: RTL

- Multi-cycle sequencer placed in front of the shared 16-bit combinational ALU.
- Implements two operation classes that the ALU cannot do in one pass:
  - 16x16 multiply, low 16 bits of the product, built from ADD and SHL steps.
  - N-bit shifts and rotates (N = 0..15), built from repeated 1-bit ALU shift steps.
- Drives the ALU control code and operands from registers and captures the ALU result each clock. The core issues one request to it and waits for a done pulse.

---
 rtl/alu_pkg.sv | 61 ++++++
 rtl/alu_seq_if.sv | 33 +++
 rtl/alu_seq.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU sequencer: ALU control codes,
// operation/state enums and flag bit positions.
package alu_pkg;

  localparam int unsigned DATA_W = 16;

  localparam logic [5:0] ALU_PASS = 6'h00;
  localparam logic [5:0] ALU_SUB  = 6'h09;
  localparam logic [5:0] ALU_ADD  = 6'h0A;
  localparam logic [5:0] ALU_SHL  = 6'h20;
  localparam logic [5:0] ALU_ROL  = 6'h22;
  localparam logic [5:0] ALU_SHR  = 6'h30;
  localparam logic [5:0] ALU_ROR  = 6'h32;
  localparam logic [5:0] ALU_SAR  = 6'h34;

  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_S = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef enum logic [2:0] {
    MUL = 3'd0,
    SHL = 3'd1,
    SHR = 3'd2,
    SAR = 3'd3,
    ROL = 3'd4,
    ROR = 3'd5
  } seq_op_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_ADD = 3'd1,
    MUL_SHL = 3'd2,
    SHIFT   = 3'd3,
    DONE    = 3'd4
  } seq_state_t;

  // Flags derived from a value alone: carry and overflow cleared.
  function automatic logic [3:0] value_flags(input logic [DATA_W-1:0] v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_S] = v[DATA_W-1];
    f[FLAG_Z] = (v == '0);
    return f;
  endfunction

  function automatic logic [5:0] shift_code(input seq_op_t op);
    logic [5:0] code;
    code = ALU_PASS;
    case (op)
      SHL:     code = ALU_SHL;
      SHR:     code = ALU_SHR;
      SAR:     code = ALU_SAR;
      ROL:     code = ALU_ROL;
      ROR:     code = ALU_ROR;
      default: code = ALU_PASS;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response and ALU-drive signals of the sequencer. The master side is
// the core plus the shared ALU; the slave side is the sequencer itself.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             i_start;
  logic [2:0]       i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_flush;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_result;
  logic [3:0]       o_flag;
  logic [5:0]       o_alu_ctrl;
  logic [WIDTH-1:0] o_alu_a;
  logic [WIDTH-1:0] o_alu_b;
  logic             o_alu_carry;
  logic [WIDTH-1:0] i_alu_data;
  logic [3:0]       i_alu_flag;

  modport master (
    output i_start, i_op, i_a, i_b, i_flush, i_alu_data, i_alu_flag,
    input  o_busy, o_done, o_result, o_flag,
           o_alu_ctrl, o_alu_a, o_alu_b, o_alu_carry
  );

  modport slave (
    input  i_start, i_op, i_a, i_b, i_flush, i_alu_data, i_alu_flag,
    output o_busy, o_done, o_result, o_flag,
           o_alu_ctrl, o_alu_a, o_alu_b, o_alu_carry
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle sequencer in front of the shared 16-bit ALU: shift-and-add
// multiply (low 16 bits) and N-bit shifts/rotates built from 1-bit ALU steps.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
) (
  input logic     i_clk,
  input logic     i_rst_n,
  alu_seq_if.slave bus
);

  seq_state_t       state;
  seq_op_t          op;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       sflag;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       flag;

  logic [5:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;

  logic             accept;
  logic             flush_now;

  assign flush_now = bus.i_flush && (state inside {MUL_ADD, MUL_SHL, SHIFT});
  assign accept    = bus.i_start && !bus.i_flush && (state inside {IDLE, DONE});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      op     <= MUL;
      p      <= '0;
      m      <= '0;
      q      <= '0;
      r      <= '0;
      cnt    <= '0;
      sflag  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      flag   <= '0;
    end else begin
      done <= 1'b0;
      if (flush_now) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
            if (accept) begin
              case (bus.i_op)
                MUL: begin
                  p     <= '0;
                  m     <= bus.i_a;
                  q     <= bus.i_b;
                  state <= MUL_ADD;
                  busy  <= 1'b1;
                end
                SHL, SHR, SAR, ROL, ROR: begin
                  op    <= seq_op_t'(bus.i_op);
                  r     <= bus.i_a;
                  cnt   <= bus.i_b[CNT_W-1:0];
                  // Seeding with the operand's own flags covers the N=0 case.
                  sflag <= value_flags(bus.i_a);
                  state <= SHIFT;
                  busy  <= 1'b1;
                end
                default: begin
                  result <= bus.i_a;
                  flag   <= value_flags(bus.i_a);
                  state  <= DONE;
                  done   <= 1'b1;
                end
              endcase
            end
          end
          MUL_ADD: begin
            if (q == '0) begin
              result <= p;
              flag   <= value_flags(p);
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else begin
              if (q[0]) p <= bus.i_alu_data;
              state <= MUL_SHL;
            end
          end
          MUL_SHL: begin
            m     <= bus.i_alu_data;
            q     <= q >> 1;
            state <= MUL_ADD;
          end
          SHIFT: begin
            if (cnt == '0) begin
              result <= r;
              flag   <= sflag;
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else begin
              r     <= bus.i_alu_data;
              sflag <= bus.i_alu_flag;
              cnt   <= cnt - CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // ALU drive depends only on registered state, never on the request inputs.
  always_comb begin
    alu_ctrl = ALU_PASS;
    alu_a    = '0;
    alu_b    = '0;
    case (state)
      MUL_ADD: begin
        if (q[0]) begin
          alu_ctrl = ALU_ADD;
          alu_a    = p;
          alu_b    = m;
        end
      end
      MUL_SHL: begin
        alu_ctrl = ALU_SHL;
        alu_a    = m;
      end
      SHIFT: begin
        if (cnt != '0) begin
          alu_ctrl = shift_code(op);
          alu_a    = r;
        end
      end
      default: ;
    endcase
  end

  assign bus.o_busy      = busy;
  assign bus.o_done      = done;
  assign bus.o_result    = result;
  assign bus.o_flag      = flag;
  assign bus.o_alu_ctrl  = alu_ctrl;
  assign bus.o_alu_a     = alu_a;
  assign bus.o_alu_b     = alu_b;
  assign bus.o_alu_carry = 1'b0;

endmodule
